rot_sequencer: RTL and testbench



---
 rtl/rot_sequencer.sv | 136 +++++++++++++
 tb/tb_rot_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rot_sequencer.sv
// ============================================================================
// rot_sequencer : position sequencer feeding the rotating-segment decoder.
//   Optional ping-pong mode when ROT_BOUNCE_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module rot_sequencer #(
  parameter int TICK_DIV  = 12500000,
  parameter int DIV_WIDTH = 27,
  parameter int N_POS     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       dir,
  input  logic [1:0] speed,
  input  logic       step_req,
  output logic [3:0] pos_out,
  output logic       tick,
  output logic       lap_done,
  output logic [7:0] lap_count
);

  localparam logic [0:0] S_PAUSE = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [3:0]           C_LAST = 4'(N_POS - 1);
  localparam logic [DIV_WIDTH-1:0] C_DIV  = DIV_WIDTH'(TICK_DIV);
  localparam logic [DIV_WIDTH-1:0] C_ONE  = DIV_WIDTH'(1);

  logic [0:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 step_q;
  logic [3:0]           pos_q, pos_d;
  logic                 tick_q, tick_d;
  logic                 lap_q, lap_d;
  logic [7:0]           laps_q, laps_d;
  logic [DIV_WIDTH-1:0] limit_m1;
  logic                 run, adv, rev, wrap;
  logic [3:0]           pos_nxt;
`ifdef ROT_BOUNCE_EN
  logic                 dirf_q, dirf_d, flag_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_PAUSE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PAUSE: if (enable)  state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_PAUSE;
      default: state_d = S_PAUSE;
    endcase
  end

  // The cycle's mode is taken from the freshly evaluated state, so the first
  // RUN cycle already counts and the first PAUSE cycle already clears cnt.
  always_comb begin
    run      = (state_d == S_RUN);
    limit_m1 = (C_DIV << speed) - C_ONE;
    adv      = run ? (cnt_q >= limit_m1) : (step_req & ~step_q);
    cnt_d    = (!run || adv) ? '0 : cnt_q + C_ONE;
    wrap     = 1'b0;
    pos_nxt  = pos_q;
`ifdef ROT_BOUNCE_EN
    rev      = run ? dirf_q : dir;
    flag_nxt = rev;
    if (!rev) begin
      if (pos_q == C_LAST) begin
        pos_nxt  = C_LAST - 4'd1;
        flag_nxt = 1'b1;
      end else begin
        pos_nxt  = pos_q + 4'd1;
      end
    end else begin
      if (pos_q == 4'd0) begin
        pos_nxt  = 4'd1;
        flag_nxt = 1'b0;
      end else begin
        pos_nxt  = pos_q - 4'd1;
        wrap     = (pos_q == 4'd1);
      end
    end
    dirf_d = adv ? flag_nxt : rev;
`else
    rev = dir;
    if (!rev) begin
      wrap    = (pos_q == C_LAST);
      pos_nxt = wrap ? 4'd0 : pos_q + 4'd1;
    end else begin
      wrap    = (pos_q == 4'd0);
      pos_nxt = wrap ? C_LAST : pos_q - 4'd1;
    end
`endif
    pos_d  = adv ? pos_nxt : pos_q;
    tick_d = adv;
    lap_d  = adv & wrap;
    laps_d = laps_q + {7'd0, lap_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
      pos_q  <= 4'd0;
      tick_q <= 1'b0;
      lap_q  <= 1'b0;
      laps_q <= 8'd0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_req;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      lap_q  <= lap_d;
      laps_q <= laps_d;
    end
  end

`ifdef ROT_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (rst) dirf_q <= 1'b0;
    else     dirf_q <= dirf_d;
  end
`endif

  assign pos_out   = pos_q;
  assign tick      = tick_q;
  assign lap_done  = lap_q;
  assign lap_count = laps_q;

endmodule

`default_nettype wire

// File: tb/tb_rot_sequencer.sv
// ============================================================================
// tb_rot_sequencer : directed self-checking bench for rot_sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_rot_sequencer;

  localparam int TD = 4;
  localparam int NP = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       step_req = 1'b0;
  logic [3:0] pos_out;
  logic       tick;
  logic       lap_done;
  logic [7:0] lap_count;

  rot_sequencer #(.TICK_DIV(TD), .DIV_WIDTH(8), .N_POS(NP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .speed(speed),
    .step_req(step_req), .pos_out(pos_out), .tick(tick),
    .lap_done(lap_done), .lap_count(lap_count)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_pos   = 4'd0;
  logic [7:0] m_laps  = 8'd0;
  logic       m_flag  = 1'b0;

  typedef struct packed {
    logic       en;
    logic       step;
    logic [3:0] pos;
    logic       tck;
  } vec_t;

  vec_t tbl [18];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compares {pos_out, tick, lap_done, lap_count} against the expectation.
  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {pos_out, tick, lap_done, lap_count};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pos=%0d tick=%0b lap=%0b laps=%0d, expected pos=%0d tick=%0b lap=%0b laps=%0d",
               name, act[13:10], act[9], act[8], act[7:0],
               exp[13:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic model_adv(output logic lap);
    lap = 1'b0;
`ifdef ROT_BOUNCE_EN
    if (!m_flag) begin
      if (m_pos == 4'(NP - 1)) begin m_pos = 4'(NP - 2); m_flag = 1'b1; end
      else m_pos = m_pos + 4'd1;
    end else begin
      if (m_pos == 4'd0) begin m_pos = 4'd1; m_flag = 1'b0; end
      else begin
        m_pos = m_pos - 4'd1;
        lap   = (m_pos == 4'd0);
      end
    end
`else
    if (!dir) begin
      if (m_pos == 4'(NP - 1)) begin m_pos = 4'd0; lap = 1'b1; end
      else m_pos = m_pos + 4'd1;
    end else begin
      if (m_pos == 4'd0) begin m_pos = 4'(NP - 1); lap = 1'b1; end
      else m_pos = m_pos - 4'd1;
    end
`endif
    if (lap) m_laps = m_laps + 8'd1;
  endtask

  // n cycles of free run; ticks expected at cycle 'first' then every 'period'.
  task automatic run_free(input string name, input int n, input int first, input int period);
    logic lap;
    logic t;
    for (int k = 1; k <= n; k++) begin
      cyc();
      lap = 1'b0;
      t   = (k >= first) && (((k - first) % period) == 0);
      if (t) model_adv(lap);
      chk(name, {m_pos, t, lap, m_laps});
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) cyc();
    chk("reset", 14'd0);
    rst    = 1'b0;
    m_pos  = 4'd0;
    m_laps = 8'd0;
    m_flag = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 4'd1, (i == 0)};
    tbl[10] = '{1'b0, 1'b0, 4'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'd3, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'd3, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 4'd3, 1'b0};  // step ignored in RUN
    tbl[16] = '{1'b0, 1'b1, 4'd3, 1'b0};  // edge register tracked it
    tbl[17] = '{1'b0, 1'b0, 4'd3, 1'b0};

`ifdef ROT_BOUNCE_EN
    enable = 1'b1; dir = 1'b0; speed = 2'd0;
    do_reset(2);
    run_free("bounce", 2 * 22 * TD, TD, TD);
`else
    // Forward free run, then enough laps to roll lap_count over.
    enable = 1'b1; dir = 1'b0; speed = 2'd0;
    do_reset(2);
    run_free("fwd_lap", 12 * TD, TD, TD);
    run_free("lap_roll", 255 * 12 * TD, TD, TD);

    // Reverse from reset wraps immediately.
    dir = 1'b1;
    do_reset(1);
    run_free("rev", 3 * TD, TD, TD);

    // Manual stepping in PAUSE.
    enable = 1'b0; dir = 1'b0;
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      enable   = tbl[i].en;
      step_req = tbl[i].step;
      cyc();
      chk($sformatf("step[%0d]", i), {tbl[i].pos, tbl[i].tck, 1'b0, 8'd0});
    end
    step_req = 1'b0;
    m_pos    = 4'd3;

    // Slowest rate, then drop to fastest mid-count.
    speed = 2'd3; enable = 1'b1;
    run_free("speed3", 2 * 8 * TD, 8 * TD, 8 * TD);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("speed3_hold", {m_pos, 1'b0, 1'b0, m_laps});
    end
    speed = 2'd0;
    begin
      logic lap;
      cyc();
      model_adv(lap);
      chk("speed_drop", {m_pos, 1'b1, lap, m_laps});
    end
    run_free("speed0", 2 * TD, TD, TD);

    // Reset in the middle of a run.
    do_reset(1);
    run_free("pre_rst", 19 * TD, TD, TD);
    do_reset(1);
    run_free("post_rst", 2 * TD, TD, TD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
